result_write_sequencer: RTL
===========================

Name: result_write_sequencer

Overview:
- Controller that drains a serial stream of computed matrix elements into the dual-port result RAM, two elements per write.
- Sits between the MAC/compute datapath (valid/ready producer) and the result-matrix block. Drives its write, addrA/addrB and dataA_in/dataB_in.
- Sequences the full address space. Captures the final matrixSum once end_operation rises, then reports done.

Parameters:
- ADDR_WIDTH, 7, result RAM address width; matrix holds DEPTH = 2**ADDR_WIDTH elements (always even).
- RESULT_WIDTH, 24, element and sum width.

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous, active-high reset
- start  in  1  one-cycle pulse, begins a matrix drain
- res_valid  in  1  producer has an element on res_data
- res_data  in  RESULT_WIDTH  element value, row-major order
- res_ready  out  1  sequencer accepts res_data this cycle
- write  out  1  write strobe to result block
- addrA  out  ADDR_WIDTH  even element address
- addrB  out  ADDR_WIDTH  odd element address (addrA+1)
- dataA_in  out  RESULT_WIDTH  even element data
- dataB_in  out  RESULT_WIDTH  odd element data
- end_operation  in  1  from result block, high when addrB is all ones
- matrixSum  in  RESULT_WIDTH  from result block, valid only while end_operation high
- busy  out  1  drain in progress (start accepted, done not yet issued)
- done  out  1  one-cycle pulse, sum_out valid
- sum_out  out  RESULT_WIDTH  registered final sum, held until next start

Behaviour:
- All outputs registered.
- Reset values: write=0, addrA=0, addrB=0, dataA_in=0, dataB_in=0, res_ready=0, busy=0, done=0, sum_out=0. State returns to IDLE.
- States: IDLE, GET_A, GET_B, ISSUE, COMMIT, CAPTURE, DONE.
- IDLE:
  - start=1 -> GET_A, busy=1.
  - pair index resets to 0; addrA/addrB are not driven to all ones.
  - start while busy is ignored.
- GET_A:
  - res_ready=1; on res_valid & res_ready, latch res_data into dataA_in -> GET_B.
- GET_B:
  - res_ready=1; on handshake, latch into dataB_in.
  - Drive addrA=2k, addrB=2k+1 -> ISSUE.
- ISSUE:
  - write=1 for exactly one cycle; res_ready=0.
- COMMIT:
  - write=0; addrA/addrB/dataA_in/dataB_in held stable.
  - Hold is required because the result block registers write one cycle before the RAM write and accumulation take effect.
  - If addrB is all ones -> CAPTURE. Otherwise k+1 -> GET_A.
- CAPTURE:
  - Addresses held at the last pair so end_operation stays high and the accumulator reflects the final pair.
  - Latch matrixSum into sum_out -> DONE.
- DONE:
  - done=1 for one cycle, busy=0 -> IDLE.
  - addrA/addrB return to 0 on entering IDLE; sum_out held.
- Throughput: 4 cycles per pair with a continuously valid producer.
  - Drain time = 2*DEPTH + 2 cycles from the first GET_A to the done pulse.
- Producer stalls (res_valid=0) hold the state indefinitely. No timeout.
- write is never asserted in consecutive cycles.
- res_ready is never high in ISSUE, COMMIT, CAPTURE, DONE or IDLE.
- Address arithmetic is modulo 2**ADDR_WIDTH. The last pair is (DEPTH-2, DEPTH-1); no wrap occurs within one drain.
- sum_out is a straight copy of matrixSum. Overflow wraps at RESULT_WIDTH bits in the result block; the sequencer does no width extension.
- Reset mid-drain:
  - Immediate return to IDLE with all outputs at reset values.
  - A write in flight (ISSUE→COMMIT) is abandoned.
  - The result block's accumulator is cleared by the same reset.

Decomposition:
- Shared package: state enum type; DEPTH and LAST_PAIR_ADDR localparams derived from ADDR_WIDTH.
- No sub-module. A single FSM plus pair counter and data registers. The top level instantiating both blocks wires the sequencer to the result block directly.

Test Plan (ADDR_WIDTH=3, RESULT_WIDTH=24, DEPTH=8):
- Reset, then start with elements 1..8 streamed continuously:
  - write pulses at pairs (0,1),(2,3),(4,5),(6,7), 4 cycles apart.
  - done asserted 18 cycles after the first GET_A.
  - sum_out=36.
- Same stream with res_valid deasserted 3 cycles before elements 3 and 6:
  - identical RAM contents and sum_out=36.
  - no write while waiting.
  - addresses/data stable through every COMMIT.
- Elements all 24'hFFFFFF: sum_out=24'hFFFFF8 (mod-2^24 wrap); RAM readback all FFFFFF.
- start pulsed again during an active drain: ignored, no restart; sum_out still 36 for the 1..8 stream.
- Reset asserted in the COMMIT of pair (2,3):
  - next cycle all outputs zero, state IDLE.
  - a subsequent full drain of 1..8 gives sum_out=36.
- Two back-to-back drains (1..8 then 10..17): second done gives sum_out=108. sum_out holds 36 until that capture.

Source files
------------

// File: rtl/result_write_sequencer_pkg.sv
// ---------------------------------------------------------------------------
// result_write_sequencer_pkg
// Shared types and sizing helpers for the result write sequencer.
//   seq_state_t      : sequencer FSM state encoding
//   depth_of()       : number of matrix elements for a given address width
//   last_pair_addr() : even address of the final element pair in a drain
// ---------------------------------------------------------------------------
package result_write_sequencer_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        GET_A   = 3'd1,
        GET_B   = 3'd2,
        ISSUE   = 3'd3,
        COMMIT  = 3'd4,
        CAPTURE = 3'd5,
        DONE    = 3'd6
    } seq_state_t;

    localparam int DEFAULT_ADDR_WIDTH   = 32'sd7;
    localparam int DEFAULT_RESULT_WIDTH = 32'sd24;

    // Matrix element count; always even because ADDR_WIDTH >= 1.
    function automatic int depth_of(input int addr_width);
        return 32'sd1 << addr_width;
    endfunction

    // The last pair written in a drain is (DEPTH-2, DEPTH-1).
    function automatic int last_pair_addr(input int addr_width);
        return depth_of(addr_width) - 32'sd2;
    endfunction

    localparam int DEFAULT_DEPTH          = depth_of(DEFAULT_ADDR_WIDTH);
    localparam int DEFAULT_LAST_PAIR_ADDR = last_pair_addr(DEFAULT_ADDR_WIDTH);

endpackage

// File: rtl/result_write_sequencer.sv
// ---------------------------------------------------------------------------
// result_write_sequencer
// Drains a serial valid/ready stream of matrix elements into the dual-port
// result RAM two elements per write, then captures the final matrix sum.
//
// Ports:
//   clock, reset          : clock and synchronous active-high reset
//   start                 : one-cycle pulse, begins a drain (ignored when busy)
//   res_valid/res_data    : producer element stream (row-major)
//   res_ready             : element accepted this cycle
//   write                 : one-cycle write strobe to result block
//   addrA/addrB           : even / odd element address of the current pair
//   dataA_in/dataB_in     : even / odd element data of the current pair
//   end_operation         : result block flag, addrB is all ones
//   matrixSum             : result block accumulator, valid with end_operation
//   busy                  : drain in progress
//   done                  : one-cycle pulse, sum_out valid
//   sum_out               : captured final sum, held until the next capture
// ---------------------------------------------------------------------------
module result_write_sequencer
    import result_write_sequencer_pkg::*;
#(
    parameter int ADDR_WIDTH   = DEFAULT_ADDR_WIDTH,
    parameter int RESULT_WIDTH = DEFAULT_RESULT_WIDTH
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    start,
    input  logic                    res_valid,
    input  logic [RESULT_WIDTH-1:0] res_data,
    output logic                    res_ready,
    output logic                    write,
    output logic [ADDR_WIDTH-1:0]   addrA,
    output logic [ADDR_WIDTH-1:0]   addrB,
    output logic [RESULT_WIDTH-1:0] dataA_in,
    output logic [RESULT_WIDTH-1:0] dataB_in,
    input  logic                    end_operation,
    input  logic [RESULT_WIDTH-1:0] matrixSum,
    output logic                    busy,
    output logic                    done,
    output logic [RESULT_WIDTH-1:0] sum_out
);

    localparam logic [ADDR_WIDTH-1:0] LAST_PAIR_ADDR = ADDR_WIDTH'(last_pair_addr(ADDR_WIDTH));
    localparam logic [ADDR_WIDTH-2:0] PAIR_STEP      = (ADDR_WIDTH-1)'(32'd1);

    seq_state_t              state_r;
    logic [ADDR_WIDTH-2:0]   pair_idx_r;   // k: current pair, addresses 2k and 2k+1

    // Sequencer FSM: all outputs are registered and updated alongside state.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_r    <= IDLE;
            pair_idx_r <= '0;
            res_ready  <= 1'b0;
            write      <= 1'b0;
            addrA      <= '0;
            addrB      <= '0;
            dataA_in   <= '0;
            dataB_in   <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            sum_out    <= '0;
        end else begin
            case (state_r)
                IDLE: begin
                    write <= 1'b0;
                    done  <= 1'b0;
                    if (start) begin
                        pair_idx_r <= '0;
                        busy       <= 1'b1;
                        res_ready  <= 1'b1;
                        state_r    <= GET_A;
                    end else begin
                        busy      <= 1'b0;
                        res_ready <= 1'b0;
                        state_r   <= IDLE;
                    end
                end
                GET_A: begin
                    if (res_valid && res_ready) begin
                        dataA_in <= res_data;
                        state_r  <= GET_B;
                    end else begin
                        state_r  <= GET_A;
                    end
                end
                GET_B: begin
                    // Second element completes the pair: present it and strobe write.
                    if (res_valid && res_ready) begin
                        dataB_in  <= res_data;
                        addrA     <= {pair_idx_r, 1'b0};
                        addrB     <= {pair_idx_r, 1'b1};
                        res_ready <= 1'b0;
                        write     <= 1'b1;
                        state_r   <= ISSUE;
                    end else begin
                        state_r   <= GET_B;
                    end
                end
                ISSUE: begin
                    write   <= 1'b0;
                    state_r <= COMMIT;
                end
                COMMIT: begin
                    // Address/data stay put this cycle: the result block acts on
                    // its registered copy of write one cycle late.
                    if (addrA == LAST_PAIR_ADDR) begin
                        state_r <= CAPTURE;
                    end else begin
                        pair_idx_r <= pair_idx_r + PAIR_STEP;
                        res_ready  <= 1'b1;
                        state_r    <= GET_A;
                    end
                end
                CAPTURE: begin
                    // Last-pair addresses are still driven, so end_operation is
                    // high and matrixSum includes the final pair.
                    if (end_operation) begin
                        sum_out <= matrixSum;
                        done    <= 1'b1;
                        busy    <= 1'b0;
                        state_r <= DONE;
                    end else begin
                        state_r <= CAPTURE;
                    end
                end
                DONE: begin
                    done    <= 1'b0;
                    addrA   <= '0;
                    addrB   <= '0;
                    state_r <= IDLE;
                end
                default: begin
                    res_ready <= 1'b0;
                    write     <= 1'b0;
                    busy      <= 1'b0;
                    done      <= 1'b0;
                    state_r   <= IDLE;
                end
            endcase
        end
    end

endmodule
